// File: rtl/vita2000_emulator_if.sv
// Link between the VITA2000 emulator and the capture side: frame enable in,
// serial lanes, sync lane and frame status out.
interface vita2000_emulator_if;
    logic        en;
    logic [3:0]  cam_d;
    logic        sync;
    logic [15:0] frame_count;
    logic        busy;

    modport master (input en, output cam_d, sync, frame_count, busy);
    modport slave  (output en, input cam_d, sync, frame_count, busy);
endinterface

// File: rtl/vita2000_emulator.sv
// Transmit-side VITA2000 model: serialises a synthetic test frame onto four
// data lanes plus the sync lane, MSB first, 10-bit word slots.
module vita2000_emulator #(
    parameter int unsigned H_WORDS = 480,
    parameter int unsigned V_LINES = 1200,
    parameter int unsigned H_BLANK = 16,
    parameter int unsigned V_BLANK = 4,
    parameter logic [9:0]  C_FS    = 10'h2AA,
    parameter logic [9:0]  C_LS    = 10'h0AA,
    parameter logic [9:0]  C_IMG   = 10'h035,
    parameter logic [9:0]  C_LE    = 10'h12A,
    parameter logic [9:0]  C_FE    = 10'h32A,
    parameter logic [9:0]  C_TR    = 10'h3A6
) (
    input  logic                  pclock,
    input  logic                  reset,
    vita2000_emulator_if.master   link
);

    localparam int unsigned VBL_SLOTS = V_BLANK * (H_WORDS + 2 + H_BLANK);
    localparam logic [15:0] PIX_LAST  = 16'(H_WORDS - 1);
    localparam logic [15:0] HBL_LAST  = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [15:0] VBL_LAST  = 16'((VBL_SLOTS > 0) ? VBL_SLOTS - 1 : 0);
    localparam logic [15:0] LINE_LAST = 16'(V_LINES - 1);

    typedef enum logic [2:0] {IDLE, SOL, PIX, EOL, HBL, VBL} state_t;

    state_t           state, state_nxt;
    logic [3:0]       bit_cnt;
    logic [15:0]      line, line_nxt;
    logic [15:0]      cnt, cnt_nxt;
    logic [9:0]       sync_word;
    logic [3:0][9:0]  lane_word;
    logic             fe_word;
    logic             line_done;
    logic             last_line;
    logic [9:0]       sh_sync;
    logic [3:0][9:0]  sh_lane;
    logic             fe_on_wire;
    logic [15:0]      frame_count;
    logic             busy;

    // state names the slot whose word is loaded at the next bit_cnt==9 edge
    always_comb begin
        state_nxt = state;
        line_nxt  = line;
        cnt_nxt   = cnt;
        sync_word = C_TR;
        lane_word = {4{C_TR}};
        fe_word   = 1'b0;
        line_done = 1'b0;
        last_line = (line == LINE_LAST);
        case (state)
            IDLE: begin
                if (link.en) begin
                    state_nxt = SOL;
                    line_nxt  = '0;
                end
            end
            SOL: begin
                sync_word = (line == '0) ? C_FS : C_LS;
                state_nxt = PIX;
                cnt_nxt   = '0;
            end
            PIX: begin
                sync_word = C_IMG;
                for (int unsigned k = 0; k < 4; k++)
                    lane_word[k] = {cnt[7:0], 2'b00} + 10'(k) + line[9:0];
                if (cnt == PIX_LAST) begin
                    state_nxt = EOL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            EOL: begin
                sync_word = last_line ? C_FE : C_LE;
                fe_word   = last_line;
                if (H_BLANK > 0) begin
                    state_nxt = HBL;
                    cnt_nxt   = '0;
                end else begin
                    line_done = 1'b1;
                end
            end
            HBL: begin
                if (cnt == HBL_LAST) line_done = 1'b1;
                else                 cnt_nxt = cnt + 16'd1;
            end
            VBL: begin
                if (cnt == VBL_LAST) begin
                    state_nxt = link.en ? SOL : IDLE;
                    line_nxt  = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // shared end-of-line exit so a zero H_BLANK / V_BLANK skips its state
        if (line_done) begin
            cnt_nxt = '0;
            if (!last_line) begin
                line_nxt  = line + 16'd1;
                state_nxt = SOL;
            end else if (VBL_SLOTS > 0) begin
                state_nxt = VBL;
            end else begin
                state_nxt = link.en ? SOL : IDLE;
                line_nxt  = '0;
            end
        end
    end

    always_ff @(posedge pclock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            line        <= '0;
            cnt         <= '0;
            sh_sync     <= '0;
            sh_lane     <= '0;
            fe_on_wire  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
                state      <= state_nxt;
                line       <= line_nxt;
                cnt        <= cnt_nxt;
                sh_sync    <= sync_word;
                sh_lane    <= lane_word;
                busy       <= (state != IDLE);
                fe_on_wire <= fe_word;
                if (fe_on_wire) frame_count <= frame_count + 16'd1;
            end else begin
                sh_sync <= {sh_sync[8:0], 1'b0};
                for (int unsigned k = 0; k < 4; k++)
                    sh_lane[k] <= {sh_lane[k][8:0], 1'b0};
            end
        end
    end

    always_comb begin
        link.cam_d = '0;
        for (int unsigned k = 0; k < 4; k++)
            link.cam_d[k] = sh_lane[k][9];
    end

    assign link.sync        = sh_sync[9];
    assign link.frame_count = frame_count;
    assign link.busy        = busy;

endmodule

// File: tb/tb_vita2000_emulator.sv
// Directed bench for vita2000_emulator: a small-frame instance for sequencing
// and a tall, blank-free instance for pixel wrap and zero-blank skipping.
module tb_vita2000_emulator;

    localparam logic [9:0] FS  = 10'h2AA;
    localparam logic [9:0] LS  = 10'h0AA;
    localparam logic [9:0] IMG = 10'h035;
    localparam logic [9:0] LE  = 10'h12A;
    localparam logic [9:0] FE  = 10'h32A;
    localparam logic [9:0] TR  = 10'h3A6;

    logic pclock;
    logic reset;

    vita2000_emulator_if link();
    vita2000_emulator_if link_w();

    vita2000_emulator #(.H_WORDS(4), .V_LINES(2), .H_BLANK(2), .V_BLANK(1)) u_dut (
        .pclock (pclock),
        .reset  (reset),
        .link   (link)
    );

    vita2000_emulator #(.H_WORDS(2), .V_LINES(1024), .H_BLANK(0), .V_BLANK(0)) u_wrap (
        .pclock (pclock),
        .reset  (reset),
        .link   (link_w)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]  w_sync, ww_sync;
    logic [9:0]  w_lane  [4];
    logic [9:0]  ww_lane [4];
    logic        w_busy, ww_busy;
    logic [15:0] w_fc, ww_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One word slot from both instances; busy/frame_count taken at the first bit.
    task automatic read_word();
        for (int b = 0; b < 10; b++) begin
            @(negedge pclock);
            if (b == 0) begin
                w_busy  = link.busy;
                w_fc    = link.frame_count;
                ww_busy = link_w.busy;
                ww_fc   = link_w.frame_count;
            end
            w_sync  = {w_sync[8:0], link.sync};
            ww_sync = {ww_sync[8:0], link_w.sync};
            for (int k = 0; k < 4; k++) begin
                w_lane[k]  = {w_lane[k][8:0], link.cam_d[k]};
                ww_lane[k] = {ww_lane[k][8:0], link_w.cam_d[k]};
            end
        end
    endtask

    // Leaves the bench aligned so the next read_word covers a full slot.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge pclock);
        check("rst_sync",  {31'd0, link.sync}, 32'd0);
        check("rst_cam_d", {28'd0, link.cam_d}, 32'd0);
        check("rst_busy",  {31'd0, link.busy}, 32'd0);
        check("rst_fc",    {16'd0, link.frame_count}, 32'd0);
        @(negedge pclock);
        reset = 1'b0;
        repeat (9) @(negedge pclock);
    endtask

    // Sync word at offset j inside a 24-slot frame (H_WORDS=4, V_LINES=2, H_BLANK=2, V_BLANK=1).
    function automatic logic [9:0] frame_sync(input int j);
        case (j)
            0:               return FS;
            1, 2, 3, 4:      return IMG;
            5:               return LE;
            8:               return LS;
            9, 10, 11, 12:   return IMG;
            13:              return FE;
            default:         return TR;
        endcase
    endfunction

    function automatic logic [9:0] frame_lane(input int j, input int k);
        if (j >= 1 && j <= 4)  return 10'(4 * (j - 1) + k);
        if (j >= 9 && j <= 12) return 10'(4 * (j - 9) + k + 1);
        return TR;
    endfunction

    task automatic check_slot(input string t, input int idx, input logic [9:0] es,
                              input int j, input logic eb, input logic [15:0] efc);
        check($sformatf("%s_sync_%0d", t, idx), {22'd0, w_sync}, {22'd0, es});
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_lane%0d_%0d", t, k, idx), {22'd0, w_lane[k]},
                  {22'd0, (j < 0) ? TR : frame_lane(j, k)});
        check($sformatf("%s_busy_%0d", t, idx), {31'd0, w_busy}, {31'd0, eb});
        check($sformatf("%s_fc_%0d", t, idx), {16'd0, w_fc}, {16'd0, efc});
    endtask

    initial begin
        reset     = 1'b1;
        link.en   = 1'b0;
        link_w.en = 1'b0;
        w_sync = '0; ww_sync = '0;
        for (int k = 0; k < 4; k++) begin w_lane[k] = '0; ww_lane[k] = '0; end

        // idle: training only
        do_reset();
        for (int i = 0; i < 19; i++) begin
            read_word();
            check_slot("idle", i, TR, -1, 1'b0, 16'd0);
        end

        // single frame, en dropped right after being taken
        link.en = 1'b1;
        for (int idx = 0; idx < 27; idx++) begin
            read_word();
            if (idx == 0) link.en = 1'b0;
            if (idx == 0 || idx > 24)
                check_slot("one", idx, TR, -1, 1'b0, 16'd1 & 16'(idx > 14));
            else
                check_slot("one", idx, frame_sync(idx - 1), idx - 1, 1'b1, 16'(idx > 14));
            if (idx == 12) begin
                check("l1w2_lane0", {22'd0, w_lane[0]}, 32'h009);
                check("l1w2_lane1", {22'd0, w_lane[1]}, 32'h00A);
                check("l1w2_lane2", {22'd0, w_lane[2]}, 32'h00B);
                check("l1w2_lane3", {22'd0, w_lane[3]}, 32'h00C);
            end
        end

        // three back-to-back frames
        do_reset();
        read_word();
        link.en = 1'b1;
        for (int idx = 0; idx < 74; idx++) begin
            read_word();
            if (idx == 49) link.en = 1'b0;
            if (idx == 0 || idx == 73)
                check_slot("b2b", idx, TR, -1, 1'b0, (idx == 73) ? 16'd3 : 16'd0);
            else
                check_slot("b2b", idx, frame_sync((idx - 1) % 24), (idx - 1) % 24, 1'b1,
                           (idx > 62) ? 16'd3 : (idx > 38) ? 16'd2 : (idx > 14) ? 16'd1 : 16'd0);
        end

        // reset in the middle of line 1 pixel slots
        do_reset();
        read_word();
        link.en = 1'b1;
        for (int idx = 0; idx < 12; idx++) read_word();
        check("pre_abort_sync", {22'd0, w_sync}, {22'd0, IMG});
        repeat (4) @(negedge pclock);
        reset   = 1'b1;
        link.en = 1'b0;
        @(negedge pclock);
        check("abort_sync",  {31'd0, link.sync}, 32'd0);
        check("abort_cam_d", {28'd0, link.cam_d}, 32'd0);
        check("abort_busy",  {31'd0, link.busy}, 32'd0);
        check("abort_fc",    {16'd0, link.frame_count}, 32'd0);
        repeat (2) @(negedge pclock);
        reset = 1'b0;
        repeat (9) @(negedge pclock);
        for (int i = 0; i < 4; i++) begin
            read_word();
            check_slot("post", i, TR, -1, 1'b0, 16'd0);
        end

        // tall frame: pixel wrap and zero-length blanking
        do_reset();
        read_word();
        link_w.en = 1'b1;
        for (int idx = 0; idx < 4098; idx++) begin
            read_word();
            case (idx)
                0:    check("w_idle", {22'd0, ww_sync}, {22'd0, TR});
                1:    check("w_fs",   {22'd0, ww_sync}, {22'd0, FS});
                2: begin
                    check("w_img",     {22'd0, ww_sync}, {22'd0, IMG});
                    check("w_l0_lane2", {22'd0, ww_lane[2]}, 32'h002);
                end
                3:    check("w_l0w1_lane3", {22'd0, ww_lane[3]}, 32'h007);
                4:    check("w_le",   {22'd0, ww_sync}, {22'd0, LE});
                5:    check("w_ls",   {22'd0, ww_sync}, {22'd0, LS});
                4082: begin
                    check("wrap_w0_lane3", {22'd0, ww_lane[3]}, 32'h3FF);
                    check("wrap_w0_lane0", {22'd0, ww_lane[0]}, 32'h3FC);
                end
                4083: begin
                    check("wrap_w1_lane0", {22'd0, ww_lane[0]}, 32'h000);
                    check("wrap_w1_lane3", {22'd0, ww_lane[3]}, 32'h003);
                end
                4096: begin
                    check("w_fe",    {22'd0, ww_sync}, {22'd0, FE});
                    check("w_fc_fe", {16'd0, ww_fc}, 32'd0);
                end
                4097: begin
                    check("w_fs2",   {22'd0, ww_sync}, {22'd0, FS});
                    check("w_busy2", {31'd0, ww_busy}, 32'd1);
                    check("w_fc2",   {16'd0, ww_fc}, 32'd1);
                end
                default: ;
            endcase
        end
        link_w.en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
